dcache_dm_wb: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache between the pipeline's MEM-stage dmem port and the shared 256-bit cacheline memory port.
- Consumes the word-aligned dmem_address, read/write strobes, wdata and byte enables produced by the MEM stage.
- Returns dmem_rdata/dmem_resp, which the pipeline's hazard logic uses to stall.
- Flop-based arrays: a hit completes in the same cycle it is presented.

---
 rtl/dcache_dm_wb_pkg.sv | 17 +
 rtl/dcache_dm_wb_array.sv | 47 ++++
 rtl/dcache_dm_wb.sv | 159 +++++++++++++++
 tb/tb_dcache_dm_wb.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_dm_wb_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
package dcache_types;

    typedef enum logic [1:0] {
        CHECK     = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } dcache_state_t;

    localparam int LINE_W     = 256;
    localparam int WORDS      = 8;
    localparam int LINE_BYTES = LINE_W / 8;
    localparam int WORD_LSB   = 2;
    localparam int INDEX_LSB  = 5;
    localparam int TAG_LSB    = 8;

endpackage

// File: rtl/dcache_dm_wb_array.sv
// Flop-based storage array: combinational read, byte-masked synchronous write,
// optional async clear for the status bits.
module dcache_array #(
    parameter int WIDTH    = 1,
    parameter int DEPTH    = 8,
    parameter bit RESET_EN = 1'b0,
    localparam int AW      = $clog2(DEPTH),
    localparam int NB      = (WIDTH + 7) / 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [NB-1:0]    be,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] bmask;

    always_comb begin
        bmask = '0;
        for (int i = 0; i < WIDTH; i++) bmask[i] = be[i / 8];
    end

    assign rdata = mem[addr];

    generate
        if (RESET_EN) begin : g_rst
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int d = 0; d < DEPTH; d++) mem[d] <= '0;
                end else if (we) begin
                    mem[addr] <= (mem[addr] & ~bmask) | (wdata & bmask);
                end
            end
        end else begin : g_norst
            logic unused_rst;
            assign unused_rst = rst;
            always_ff @(posedge clk) begin
                if (we) mem[addr] <= (mem[addr] & ~bmask) | (wdata & bmask);
            end
        end
    endgenerate

endmodule

// File: rtl/dcache_dm_wb.sv
// Direct-mapped, write-back, write-allocate data cache; hits respond in the
// cycle they are presented, misses run WRITEBACK (if dirty) then ALLOCATE.
module dcache_dm_wb #(
    parameter int S_INDEX  = 3,
    parameter int S_OFFSET = 5,
    parameter int S_TAG    = 32 - S_INDEX - S_OFFSET
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [31:0]  mem_address,
    input  logic [31:0]  mem_wdata,
    input  logic [3:0]   mem_byte_enable,
    output logic [31:0]  mem_rdata,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);
    import dcache_types::*;

    localparam int SETS = 2 ** S_INDEX;
    localparam int NBYTES = LINE_W / 8;

    dcache_state_t state, state_next;

    logic [S_TAG-1:0]    tag;
    logic [S_INDEX-1:0]  index;
    logic [S_OFFSET-3:0] word;
    logic [1:0]          unused_addr_lo;

    assign tag            = mem_address[31 -: S_TAG];
    assign index          = mem_address[S_OFFSET +: S_INDEX];
    assign word           = mem_address[S_OFFSET-1:2];
    assign unused_addr_lo = mem_address[1:0];

    // Miss address is latched so a dropped/changed request cannot corrupt the fill.
    logic [S_TAG-1:0]   miss_tag;
    logic [S_INDEX-1:0] miss_index;
    logic               miss_ld;
    logic [S_INDEX-1:0] arr_index;

    assign arr_index = (state == CHECK) ? index : miss_index;

    logic [LINE_W-1:0] data_rd, data_wdata;
    logic [NBYTES-1:0] data_be, line_be;
    logic              data_we;
    logic [S_TAG-1:0]  tag_rd;
    logic              tag_we;
    logic [0:0]        valid_rd, dirty_rd, valid_wd, dirty_wd;
    logic              valid_we, dirty_we;
    logic              req, hit;

    assign req       = mem_read | mem_write;
    assign hit       = valid_rd[0] & (tag_rd == tag);
    assign line_be   = NBYTES'(mem_byte_enable) << {word, 2'b00};
    assign mem_rdata = data_rd[word*32 +: 32];
    assign pmem_wdata = data_rd;

    dcache_array #(.WIDTH(LINE_W), .DEPTH(SETS), .RESET_EN(1'b0)) u_data (
        .clk(clk), .rst(rst), .we(data_we), .addr(arr_index),
        .be(data_be), .wdata(data_wdata), .rdata(data_rd)
    );

    dcache_array #(.WIDTH(S_TAG), .DEPTH(SETS), .RESET_EN(1'b0)) u_tag (
        .clk(clk), .rst(rst), .we(tag_we), .addr(arr_index),
        .be('1), .wdata(miss_tag), .rdata(tag_rd)
    );

    dcache_array #(.WIDTH(1), .DEPTH(SETS), .RESET_EN(1'b1)) u_valid (
        .clk(clk), .rst(rst), .we(valid_we), .addr(arr_index),
        .be(1'b1), .wdata(valid_wd), .rdata(valid_rd)
    );

    dcache_array #(.WIDTH(1), .DEPTH(SETS), .RESET_EN(1'b1)) u_dirty (
        .clk(clk), .rst(rst), .we(dirty_we), .addr(arr_index),
        .be(1'b1), .wdata(dirty_wd), .rdata(dirty_rd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= CHECK;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_tag   <= '0;
            miss_index <= '0;
        end else if (miss_ld) begin
            miss_tag   <= tag;
            miss_index <= index;
        end
    end

    always_comb begin
        state_next   = state;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        data_we      = 1'b0;
        data_be      = '0;
        data_wdata   = '0;
        tag_we       = 1'b0;
        valid_we     = 1'b0;
        valid_wd     = 1'b0;
        dirty_we     = 1'b0;
        dirty_wd     = 1'b0;
        miss_ld      = 1'b0;
        case (state)
            CHECK: begin
                if (req) begin
                    if (hit) begin
                        mem_resp = 1'b1;
                        // A simultaneous read+write is handled as a write.
                        if (mem_write) begin
                            data_we    = 1'b1;
                            data_be    = line_be;
                            data_wdata = {(LINE_W/32){mem_wdata}};
                            dirty_we   = 1'b1;
                            dirty_wd   = 1'b1;
                        end
                    end else begin
                        miss_ld    = 1'b1;
                        state_next = (dirty_rd[0] & valid_rd[0]) ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_rd, miss_index, {S_OFFSET{1'b0}}};
                if (pmem_resp) begin
                    dirty_we   = 1'b1;
                    state_next = ALLOCATE;
                end
            end
            ALLOCATE: begin
                pmem_read    = 1'b1;
                pmem_address = {miss_tag, miss_index, {S_OFFSET{1'b0}}};
                if (pmem_resp) begin
                    data_we    = 1'b1;
                    data_be    = '1;
                    data_wdata = pmem_rdata;
                    tag_we     = 1'b1;
                    valid_we   = 1'b1;
                    valid_wd   = 1'b1;
                    dirty_we   = 1'b1;
                    state_next = CHECK;
                end
            end
            default: state_next = CHECK;
        endcase
    end

endmodule

// File: tb/tb_dcache_dm_wb.sv
// Scoreboard bench for dcache_dm_wb: directed requests, behavioural pmem,
// and a negedge monitor checking every mem_resp against a queue of expectations.
module tb_dcache_dm_wb;

    localparam int L = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_read, mem_write;
    logic [31:0]  mem_address, mem_wdata, mem_rdata;
    logic [3:0]   mem_byte_enable;
    logic         mem_resp;
    logic         pmem_read, pmem_write, pmem_resp;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata, pmem_rdata;

    always #5 clk = ~clk;

    dcache_dm_wb dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    typedef struct {
        logic        chk;
        logic [31:0] data;
    } exp_t;

    exp_t         exp_q[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    logic [255:0] bmem [logic [31:0]];
    logic [255:0] line120, line1120, line140, exp_wb;
    logic [31:0]  wb_addr, rd_addr;
    logic [255:0] wb_data;
    int           n_txn = 0;
    int           overlap = 0;
    int           stab_err = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Behavioural pmem: L wait cycles, then a one-cycle pmem_resp.
    initial begin
        int wcnt;
        wcnt = 0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || !(pmem_read || pmem_write)) begin
                pmem_resp = 1'b0;
                wcnt = 0;
            end else if (wcnt == L) begin
                pmem_resp = 1'b1;
                wcnt = 0;
                n_txn++;
                if (pmem_write) begin
                    bmem[pmem_address] = pmem_wdata;
                    wb_addr = pmem_address;
                    wb_data = pmem_wdata;
                end else begin
                    rd_addr = pmem_address;
                    pmem_rdata = bmem.exists(pmem_address) ? bmem[pmem_address] : '0;
                end
            end else begin
                pmem_resp = 1'b0;
                wcnt++;
            end
        end
    end

    // Scoreboard monitor and pmem protocol watchers.
    logic         wb_prev = 1'b0;
    logic [31:0]  wb_a;
    logic [255:0] wb_d;
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_resp) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got resp with empty queue, expected none");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.chk) check("rdata", 256'(mem_rdata), 256'(e.data));
                end
            end
            if (pmem_read && pmem_write) overlap++;
            if (pmem_write) begin
                if (wb_prev && (pmem_address !== wb_a || pmem_wdata !== wb_d)) stab_err++;
                wb_prev = 1'b1;
                wb_a = pmem_address;
                wb_d = pmem_wdata;
            end else begin
                wb_prev = 1'b0;
            end
        end
    end

    task automatic do_req(input string name, input logic [31:0] a, input logic wr,
                          input logic [3:0] be, input logic [31:0] wd,
                          input logic [31:0] exp, input int exp_lat);
        exp_t e;
        int   lat;
        logic done;
        @(posedge clk);
        #1;
        mem_address = a;
        mem_read = !wr;
        mem_write = wr;
        mem_byte_enable = be;
        mem_wdata = wd;
        e.chk = !wr;
        e.data = exp;
        exp_q.push_back(e);
        lat = 0;
        done = 1'b0;
        while (!done && lat < 100) begin
            @(negedge clk);
            if (mem_resp) done = 1'b1;
            else lat++;
        end
        check({name, "_latency"}, 256'(lat), 256'(exp_lat));
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        int t0, idle_err, waited;
        rst = 1'b1;
        mem_read = 1'b0;
        mem_write = 1'b0;
        mem_address = '0;
        mem_wdata = '0;
        mem_byte_enable = '0;
        for (int i = 0; i < 8; i++) begin
            line120[i*32 +: 32]  = 32'h0120_0000 + i;
            line1120[i*32 +: 32] = 32'h1120_0000 + i;
            line140[i*32 +: 32]  = 32'h0140_0000 + i;
        end
        line120[31:0]   = 32'hDEADBEEF;
        line120[63:32]  = 32'h11223344;
        line1120[31:0]  = 32'hCAFEF00D;
        line140[31:0]   = 32'h0BADF00D;
        bmem[32'h0000_0120] = line120;
        bmem[32'h0000_1120] = line1120;
        bmem[32'h0000_0140] = line140;

        repeat (3) @(negedge clk);
        check("reset_mem_resp", 256'(mem_resp), 256'(0));
        check("reset_pmem_read", 256'(pmem_read), 256'(0));
        check("reset_pmem_write", 256'(pmem_write), 256'(0));
        check("reset_pmem_address", 256'(pmem_address), 256'(0));
        rst = 1'b0;

        // Cold read miss: clean, resp after L+2 cycles.
        do_req("cold_read", 32'h0000_0120, 1'b0, 4'h0, 32'h0, 32'hDEADBEEF, L + 2);
        check("cold_fill_addr", 256'(rd_addr), 256'(32'h0000_0120));

        t0 = n_txn;
        do_req("read_hit", 32'h0000_0120, 1'b0, 4'h0, 32'h0, 32'hDEADBEEF, 0);
        check("hit_no_pmem", 256'(n_txn), 256'(t0));

        do_req("byte_store", 32'h0000_0124, 1'b1, 4'b0100, 32'h00AB_0000, 32'h0, 0);
        do_req("read_after_store", 32'h0000_0124, 1'b0, 4'h0, 32'h0, 32'h11AB3344, 0);

        // Dirty eviction: writeback of index 1, then fill of the new tag.
        exp_wb = line120;
        exp_wb[63:32] = 32'h11AB3344;
        do_req("dirty_evict", 32'h0000_1120, 1'b0, 4'h0, 32'h0, 32'hCAFEF00D, 2 * (L + 1) + 1);
        check("wb_addr", 256'(wb_addr), 256'(32'h0000_0120));
        check("wb_data", wb_data, exp_wb);
        check("evict_fill_addr", 256'(rd_addr), 256'(32'h0000_1120));

        do_req("zero_be_store", 32'h0000_1120, 1'b1, 4'b0000, 32'hFFFF_FFFF, 32'h0, 0);
        do_req("read_after_zero_be", 32'h0000_1120, 1'b0, 4'h0, 32'h0, 32'hCAFEF00D, 0);

        // Reset while ALLOCATE is outstanding.
        @(posedge clk);
        #1;
        mem_address = 32'h0000_0140;
        mem_read = 1'b1;
        waited = 0;
        while (!pmem_read && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("alloc_seen_before_reset", 256'(pmem_read), 256'(1));
        rst = 1'b1;
        #1;
        check("reset_drops_pmem_read", 256'(pmem_read), 256'(0));
        check("reset_clears_pmem_addr", 256'(pmem_address), 256'(0));
        mem_read = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        do_req("reread_after_reset", 32'h0000_0140, 1'b0, 4'h0, 32'h0, 32'h0BADF00D, L + 2);

        idle_err = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_resp || pmem_read || pmem_write) idle_err++;
        end
        check("idle_quiet", 256'(idle_err), 256'(0));

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 256'(exp_q.size()), 256'(0));
        check("pmem_strobe_overlap", 256'(overlap), 256'(0));
        check("wb_stable", 256'(stab_err), 256'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
